param_updown_counter: RTL
=========================

// Module: param_updown_counter
// PURPOSE
//  Parametrised modulo-N counter: generalises the lab's fixed 4-bit counter.
//  Adds width/modulo parameters, a built-in prescaler, up/down/bounce modes,
//  synchronous clear and parallel load, and a terminal-count pulse.
//  Feeds board-level display/timing logic (7-seg digit counters, LED
//  sequencers), where it is cascaded via tc -> en.
// PARAMETERS
//  WIDTH     4   count register width in bits
//  MODULO    16  count range 0..MODULO-1; legal range 2 <= MODULO <= 2**WIDTH
//  PRESCALE  1   en-qualified cycles per count step; >=1, 1 = step on every enabled cycle
//  PS_WIDTH  1   prescaler width; must satisfy 2**PS_WIDTH >= PRESCALE
// PORTS
//  clk       in   1      single clock, rising edge
//  reset_n   in   1      asynchronous, active-low reset
//  en        in   1      count enable; gates the prescaler
//  clr       in   1      synchronous clear
//  load      in   1      synchronous parallel load
//  load_val  in   WIDTH  value to load
//  mode      in   2      00 up, 01 down, 10 bounce, 11 hold (treated as en=0)
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered, 1 cycle wide
//  dir       out  1      current direction: 1 = up, 0 = down
//  load_err  out  1      1-cycle pulse: load_val >= MODULO was clamped
// BEHAVIOUR
//  Clock and reset:
//   - One clock domain. reset_n low asynchronously forces:
//     count=0, tc=0, dir=1, load_err=0, prescaler=0.
//   - Reset asserted mid-operation aborts everything; counting restarts from 0.
//  Priority per edge: clr > load > step.
//   - clr: count=0, prescaler=0, dir=1, tc=0.
//   - load: count=min(load_val, MODULO-1), prescaler=0, tc=0.
//     load_err=1 for one cycle if clamped. dir is unchanged.
//  Prescaler:
//   - Increments on every en=1 cycle (mode!=11).
//   - step = en & (ps==PRESCALE-1); ps then returns to 0.
//   - ps holds its value while en=0.
//  Step, by mode:
//   - up: count+1; MODULO-1 -> 0 with tc=1.
//   - down: count-1; 0 -> MODULO-1 with tc=1.
//   - bounce: count moves in direction dir.
//     Reverses at the endpoints without repeating them
//     (..., M-2, M-1, M-2, ..., 1, 0, 1, ...).
//     tc=1 on the step that lands on M-1 (going up) or 0 (going down).
//     dir flips on the step leaving the endpoint.
//  dir in non-bounce modes: up -> dir=1, down -> dir=0.
//  tc: asserted on the same edge that updates count; low on every other cycle.
//  Latency: count and tc change 1 edge after the qualifying step cycle.
//  Mode change: takes effect on the next step; count is preserved.
//   - Entering bounce with count=M-1 and dir=1: first step goes to M-2.
//  Arithmetic:
//   - All compares are against MODULO-1 at WIDTH bits. No carry out.
//   - count never exceeds MODULO-1.
// STRUCTURE
//  Shared header counter_defs.vh (included, not duplicated):
//   - MODE_UP / MODE_DOWN / MODE_BOUNCE / MODE_HOLD localparams.
//  Sub-module prescaler_tick (PRESCALE, PS_WIDTH):
//   - Inputs: clk, reset_n, en, restart.
//   - Output: step.
//  Top level: one always block for count/dir/tc/load_err. No latches.
// TESTING
//  1. Defaults, en=1, mode=up, 20 cycles:
//     count 0..15,0..3; tc high only on the edge 15->0.
//  2. mode=down, PRESCALE=3:
//     count steps every 3rd enabled cycle, 0 -> 15 (tc=1) -> 14.
//     Dropping en for 2 cycles stretches the period by exactly 2.
//  3. MODULO=10, mode=bounce, from reset:
//     0,1,...,9(tc),8,...,0(tc),1; dir falls on the step 9->8.
//  4. Load precedence:
//     clr=1 & load=1 -> count=0.
//     load=1, load_val=12 with MODULO=10 -> count=9, load_err pulses one cycle.
//  5. Async reset mid-count:
//     count=7 with tc high, drop reset_n between edges ->
//     count=0, tc=0, dir=1 immediately, without waiting for an edge.
//  6. Cascade: tc of instance A drives en of instance B (both MODULO=10):
//     B increments once per 10 A steps; pair reads 00..99 then wraps.

Source files
------------

// File: rtl/param_updown_counter_pkg.sv
// ---------------------------------------------------------------------------
// param_updown_counter_pkg
//   Shared definitions for the parametrised up/down/bounce counter.
//   Holds the mode encoding used on the 'mode' port and by the testbench.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package param_updown_counter_pkg;

    // Encoding of the 2-bit 'mode' port.
    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    // Hold behaves exactly like en=0: no prescaler advance, no step.
    function automatic logic mode_counts(input logic [1:0] mode);
        return (mode_e'(mode) != MODE_HOLD);
    endfunction

endpackage

// File: rtl/param_updown_counter_prescaler_tick.sv
// ---------------------------------------------------------------------------
// prescaler_tick
//   Divides the enable by PRESCALE: 'step' is high on every PRESCALE-th
//   enabled cycle. The phase counter holds while 'en' is low, so an idle
//   gap stretches the step period by exactly the gap length.
//   Ports:
//     clk      in   rising-edge clock
//     reset_n  in   asynchronous active-low reset (phase -> 0)
//     en       in   qualified enable; advances the phase
//     restart  in   synchronous phase clear (clr/load in the parent)
//     step     out  combinational; high on the cycle the phase wraps
// ---------------------------------------------------------------------------
module prescaler_tick #(
    parameter int PRESCALE = 1,
    parameter int PS_WIDTH = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic step
);

    localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);
    localparam logic [PS_WIDTH-1:0] PS_ONE  = PS_WIDTH'(1);

    logic [PS_WIDTH-1:0] ps;
    logic                ps_wrap;

    assign ps_wrap = (ps == PS_LAST);
    assign step    = en & ps_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps <= '0;
        end else if (restart) begin
            ps <= '0;
        end else if (en) begin
            ps <= ps_wrap ? '0 : (ps + PS_ONE);
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// ---------------------------------------------------------------------------
// param_updown_counter
//   Modulo-MODULO counter with prescaler, up/down/bounce modes, synchronous
//   clear and clamped parallel load, and a registered terminal-count pulse
//   intended for cascading (tc of one stage -> en of the next).
//   Parameters:
//     WIDTH     count width;   MODULO    count range 0..MODULO-1
//     PRESCALE  enabled cycles per step; PS_WIDTH prescaler width
//   Ports:
//     clk       in   rising-edge clock
//     reset_n   in   asynchronous active-low reset
//     en        in   count enable (gates the prescaler)
//     clr       in   synchronous clear (highest priority)
//     load      in   synchronous load of load_val (clamped to MODULO-1)
//     load_val  in   value to load
//     mode      in   00 up, 01 down, 10 bounce, 11 hold
//     count     out  registered count
//     tc        out  registered one-cycle terminal-count pulse
//     dir       out  current direction, 1 = up
//     load_err  out  one-cycle pulse when a load was clamped
// ---------------------------------------------------------------------------
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter int PRESCALE = 1,
    parameter int PS_WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             dir,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] CNT_PEN = WIDTH'(MODULO - 2);
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    // One extra bit so MODULO == 2**WIDTH is representable in the clamp test.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic             count_en;
    logic             restart;
    logic             step;
    logic             clamp;
    logic [WIDTH-1:0] nxt_count;
    logic             nxt_dir;
    logic             nxt_tc;

    assign count_en = en & mode_counts(mode);
    assign restart  = clr | load;
    assign clamp    = ({1'b0, load_val} >= MOD_EXT);

    prescaler_tick #(
        .PRESCALE (PRESCALE),
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (count_en),
        .restart (restart),
        .step    (step)
    );

    // Result of one count step in the current mode; only applied when 'step'.
    always_comb begin
        nxt_count = count;
        nxt_dir   = dir;
        nxt_tc    = 1'b0;
        unique case (mode_e'(mode))
            MODE_UP: begin
                nxt_dir = 1'b1;
                if (count == CNT_MAX) begin
                    nxt_count = '0;
                    nxt_tc    = 1'b1;
                end else begin
                    nxt_count = count + CNT_ONE;
                end
            end
            MODE_DOWN: begin
                nxt_dir = 1'b0;
                if (count == '0) begin
                    nxt_count = CNT_MAX;
                    nxt_tc    = 1'b1;
                end else begin
                    nxt_count = count - CNT_ONE;
                end
            end
            MODE_BOUNCE: begin
                // Endpoints are visited once; dir flips on the step that
                // leaves an endpoint, tc marks landing on one.
                if (dir) begin
                    if (count == CNT_MAX) begin
                        nxt_count = CNT_PEN;
                        nxt_dir   = 1'b0;
                        nxt_tc    = (CNT_PEN == '0);
                    end else begin
                        nxt_count = count + CNT_ONE;
                        nxt_tc    = (count == CNT_PEN);
                    end
                end else begin
                    if (count == '0) begin
                        nxt_count = CNT_ONE;
                        nxt_dir   = 1'b1;
                        nxt_tc    = (CNT_MAX == CNT_ONE);
                    end else begin
                        nxt_count = count - CNT_ONE;
                        nxt_tc    = (count == CNT_ONE);
                    end
                end
            end
            MODE_HOLD: begin
                nxt_count = count;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            tc       <= 1'b0;
            dir      <= 1'b1;
            load_err <= 1'b0;
        end else begin
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                count <= '0;
                dir   <= 1'b1;
            end else if (load) begin
                if (clamp) begin
                    count    <= CNT_MAX;
                    load_err <= 1'b1;
                end else begin
                    count    <= load_val;
                end
            end else if (step) begin
                count <= nxt_count;
                dir   <= nxt_dir;
                tc    <= nxt_tc;
            end
        end
    end

endmodule
